// File: rtl/sata_prim_pkg.sv
// SATA primitive codes, dword encodings and K-character constants shared by
// the RX decoder, the TX primitive mux and the OOB controller.
package sata_prim_pkg;

   typedef enum logic [4:0] {
      P_NONE = 5'd0, P_ALIGN, P_CONT, P_SYNC, P_R_RDY, P_R_IP, P_R_OK, P_R_ERR,
      P_SOF, P_EOF, P_X_RDY, P_WTRM, P_HOLD, P_HOLDA, P_DMAT,
      P_PMREQ_P, P_PMREQ_S, P_PMACK, P_PMNAK
   } prim_code_t;

   typedef enum logic {ST_IDLE, ST_FRAME} frame_state_t;

   localparam logic [7:0] K28_3  = 8'h7C;
   localparam logic [7:0] K28_5  = 8'hBC;
   localparam logic [3:0] K_DATA = 4'b0000;
   localparam logic [3:0] K_PRIM = 4'b0001;

   // Byte0 (first on the wire) sits in bits [7:0].
   localparam logic [31:0] PRIM_ALIGN   = 32'h7B4A4ABC;
   localparam logic [31:0] PRIM_CONT    = 32'h9999AA7C;
   localparam logic [31:0] PRIM_SYNC    = 32'hB5B5957C;
   localparam logic [31:0] PRIM_R_RDY   = 32'h4A4A957C;
   localparam logic [31:0] PRIM_R_IP    = 32'h5555B57C;
   localparam logic [31:0] PRIM_R_OK    = 32'h3535B57C;
   localparam logic [31:0] PRIM_R_ERR   = 32'h5656B57C;
   localparam logic [31:0] PRIM_SOF     = 32'h3737B57C;
   localparam logic [31:0] PRIM_EOF     = 32'hD5D5B57C;
   localparam logic [31:0] PRIM_X_RDY   = 32'h5757B57C;
   localparam logic [31:0] PRIM_WTRM    = 32'h5858B57C;
   localparam logic [31:0] PRIM_HOLD    = 32'hD5D5AA7C;
   localparam logic [31:0] PRIM_HOLDA   = 32'h9595AA7C;
   localparam logic [31:0] PRIM_DMAT    = 32'h3636B57C;
   localparam logic [31:0] PRIM_PMREQ_P = 32'h1717B57C;
   localparam logic [31:0] PRIM_PMREQ_S = 32'h7575957C;
   localparam logic [31:0] PRIM_PMACK   = 32'h9595957C;
   localparam logic [31:0] PRIM_PMNAK   = 32'hF5F5957C;

   function automatic logic is_prim_k(input logic [7:0] b);
      return (b == K28_3) || (b == K28_5);
   endfunction

endpackage

// File: rtl/sata_rx_prim_decode_if.sv
// Decoded RX link stream: primitive code plus payload dword strobe toward the
// link-layer receive FSM and RX FIFO.
interface sata_rx_prim_decode_if;
   import sata_prim_pkg::*;

   logic         prim_valid;
   prim_code_t   prim_code;
   logic         data_valid;
   logic [31:0]  data_o;
   logic         frame_active;
   logic         cont_active;
   logic         err_pulse;

   modport master (output prim_valid, prim_code, data_valid, data_o,
                   frame_active, cont_active, err_pulse);
   modport slave  (input  prim_valid, prim_code, data_valid, data_o,
                   frame_active, cont_active, err_pulse);
endinterface

// File: rtl/sata_prim_lookup.sv
// Combinational dword -> primitive code table; P_NONE for anything unmatched.
module sata_prim_lookup
   import sata_prim_pkg::*;
(
   input  logic [31:0] dword,
   output prim_code_t  code
);

   always_comb begin
      code = P_NONE;
      case (dword)
         PRIM_ALIGN:   code = P_ALIGN;
         PRIM_CONT:    code = P_CONT;
         PRIM_SYNC:    code = P_SYNC;
         PRIM_R_RDY:   code = P_R_RDY;
         PRIM_R_IP:    code = P_R_IP;
         PRIM_R_OK:    code = P_R_OK;
         PRIM_R_ERR:   code = P_R_ERR;
         PRIM_SOF:     code = P_SOF;
         PRIM_EOF:     code = P_EOF;
         PRIM_X_RDY:   code = P_X_RDY;
         PRIM_WTRM:    code = P_WTRM;
         PRIM_HOLD:    code = P_HOLD;
         PRIM_HOLDA:   code = P_HOLDA;
         PRIM_DMAT:    code = P_DMAT;
         PRIM_PMREQ_P: code = P_PMREQ_P;
         PRIM_PMREQ_S: code = P_PMREQ_S;
         PRIM_PMACK:   code = P_PMACK;
         PRIM_PMNAK:   code = P_PMNAK;
         default:      code = P_NONE;
      endcase
   end

endmodule

// File: rtl/sata_rx_prim_decode.sv
// RX link front end: drops ALIGNp, classifies primitives, expands CONTp and
// frames payload dwords between SOFp and EOFp/WTRMp/SYNCp. One register stage.
module sata_rx_prim_decode
   import sata_prim_pkg::*;
#(
   parameter int C_CHIPSCOPE = 0,
   parameter int C_ERRCNT_W  = 16
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst_n,
   input  logic                   link_up,
   input  logic [31:0]            rxdata,
   input  logic [3:0]             rxdatak,
   input  logic                   rxbyteisaligned,
   sata_rx_prim_decode_if.master  prim,
   output logic [C_ERRCNT_W-1:0]  err_cnt,
   output logic [C_ERRCNT_W-1:0]  align_cnt,
   inout  wire  [35:0]            CONTROL,
   output logic                   trig_o
);

   frame_state_t state_q, nxt_state;
   prim_code_t   last_q, nxt_last, lk_code, pc_d;
   logic         cont_q, nxt_cont;
   logic         pv_d, dv_d, err_d, align_d, k_ok;
   logic [31:0]  do_d;

   sata_prim_lookup u_lookup (.dword(rxdata), .code(lk_code));

   assign k_ok = (rxdatak == K_PRIM) && is_prim_k(rxdata[7:0]);

   always_comb begin
      nxt_state = state_q;
      nxt_cont  = cont_q;
      nxt_last  = last_q;
      pv_d      = 1'b0;
      pc_d      = P_NONE;
      dv_d      = 1'b0;
      do_d      = '0;
      err_d     = 1'b0;
      align_d   = 1'b0;
      if (!(link_up && rxbyteisaligned)) begin
         // Link loss is not an error; it just forgets all context.
         nxt_state = ST_IDLE;
         nxt_cont  = 1'b0;
         nxt_last  = P_NONE;
      end else if (rxdatak == K_DATA) begin
         if (cont_q) begin
            // Scrambled filler during CONT: repeat the held primitive, drop the dword.
            pv_d = 1'b1;
            pc_d = last_q;
         end else if (state_q == ST_FRAME) begin
            dv_d = 1'b1;
            do_d = rxdata;
         end else begin
            err_d = 1'b1;
         end
      end else if (!k_ok || lk_code == P_NONE) begin
         err_d = 1'b1;
      end else if (lk_code == P_ALIGN) begin
         align_d = 1'b1;
      end else if (lk_code == P_CONT) begin
         if (last_q == P_NONE) begin
            err_d = 1'b1;
         end else begin
            nxt_cont = 1'b1;
            pv_d     = 1'b1;
            pc_d     = last_q;
         end
      end else begin
         pv_d     = 1'b1;
         pc_d     = lk_code;
         nxt_last = lk_code;
         nxt_cont = 1'b0;
         case (lk_code)
            P_SOF: begin
               err_d     = (state_q == ST_FRAME);
               nxt_state = ST_FRAME;
            end
            P_EOF, P_WTRM, P_SYNC: nxt_state = ST_IDLE;
            default: ;
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= ST_IDLE;
         cont_q  <= 1'b0;
         last_q  <= P_NONE;
      end else begin
         state_q <= nxt_state;
         cont_q  <= nxt_cont;
         last_q  <= nxt_last;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         prim.prim_valid   <= 1'b0;
         prim.prim_code    <= P_NONE;
         prim.data_valid   <= 1'b0;
         prim.data_o       <= '0;
         prim.frame_active <= 1'b0;
         prim.cont_active  <= 1'b0;
         prim.err_pulse    <= 1'b0;
         err_cnt           <= '0;
         align_cnt         <= '0;
      end else begin
         prim.prim_valid   <= pv_d;
         prim.prim_code    <= pc_d;
         prim.data_valid   <= dv_d;
         prim.data_o       <= do_d;
         prim.frame_active <= (nxt_state == ST_FRAME);
         prim.cont_active  <= nxt_cont;
         prim.err_pulse    <= err_d;
         if (err_d && !(&err_cnt))
            err_cnt <= err_cnt + 1'b1;
         if (align_d && !(&align_cnt))
            align_cnt <= align_cnt + 1'b1;
      end
   end

   // The ILA core attaches to CONTROL at chip integration; this block only
   // supplies its trigger and never drives the bus itself.
   assign CONTROL = {36{1'bz}};

   generate
      if (C_CHIPSCOPE != 0) begin : g_cs
         assign trig_o = prim.err_pulse;
      end else begin : g_no_cs
         assign trig_o = 1'b0;
      end
   endgenerate

endmodule

// File: tb/tb_sata_rx_prim_decode.sv
// Directed stimulus with a queued scoreboard: each driven dword pushes its
// expected registered response, a monitor pops and compares one cycle later.
module tb_sata_rx_prim_decode;
   import sata_prim_pkg::*;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        link_up = 1'b0;
   logic        rxbyteisaligned = 1'b1;
   logic [31:0] rxdata = '0;
   logic [3:0]  rxdatak = '0;
   wire  [35:0] control, control2;
   logic        trig, trig2;
   logic [15:0] err_cnt, align_cnt;
   logic [2:0]  err_cnt2, align_cnt2;

   sata_rx_prim_decode_if dec ();
   sata_rx_prim_decode_if dec2 ();

   always #5 sys_clk = ~sys_clk;

   sata_rx_prim_decode #(.C_CHIPSCOPE(0), .C_ERRCNT_W(16)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .link_up(link_up),
      .rxdata(rxdata), .rxdatak(rxdatak), .rxbyteisaligned(rxbyteisaligned),
      .prim(dec), .err_cnt(err_cnt), .align_cnt(align_cnt),
      .CONTROL(control), .trig_o(trig));

   // Narrow-counter instance to reach saturation quickly; ILA trigger enabled.
   sata_rx_prim_decode #(.C_CHIPSCOPE(1), .C_ERRCNT_W(3)) dut_sat (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .link_up(link_up),
      .rxdata(rxdata), .rxdatak(rxdatak), .rxbyteisaligned(rxbyteisaligned),
      .prim(dec2), .err_cnt(err_cnt2), .align_cnt(align_cnt2),
      .CONTROL(control2), .trig_o(trig2));

   typedef struct {
      logic        pv;
      prim_code_t  pc;
      logic        dv;
      logic [31:0] dout;
      logic        fa, ca, ep;
      int          ec, ac;
   } exp_t;

   exp_t q[$];
   int   checks = 0, failures = 0;
   int   e_ec = 0, e_ac = 0;
   bit   rst_mode = 1'b1;
   bit   bia_mode = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic int sat7(input int v);
      return (v > 7) ? 7 : v;
   endfunction

   task automatic step(input logic lu, input logic [3:0] k, input logic [31:0] d,
                       input logic pv, input prim_code_t pc, input logic dv,
                       input logic fa, input logic ca, input logic ep, input logic al);
      exp_t e;
      @(negedge sys_clk);
      sys_rst_n       = !rst_mode;
      rxbyteisaligned = bia_mode;
      link_up         = lu;
      rxdatak         = k;
      rxdata          = d;
      if (rst_mode) begin
         e_ec = 0;
         e_ac = 0;
         e = '{pv:1'b0, pc:P_NONE, dv:1'b0, dout:32'h0, fa:1'b0, ca:1'b0, ep:1'b0, ec:0, ac:0};
      end else begin
         e_ec += int'(ep);
         e_ac += int'(al);
         e = '{pv:pv, pc:pc, dv:dv, dout:(dv ? d : 32'h0), fa:fa, ca:ca, ep:ep, ec:e_ec, ac:e_ac};
      end
      q.push_back(e);
   endtask

   task automatic pr(input logic [31:0] d, input prim_code_t pc, input logic fa, input logic ca);
      step(1'b1, K_PRIM, d, 1'b1, pc, 1'b0, fa, ca, 1'b0, 1'b0);
   endtask
   task automatic dat(input logic [31:0] d);
      step(1'b1, K_DATA, d, 1'b0, P_NONE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask
   task automatic junk(input logic [31:0] d, input prim_code_t pc, input logic fa);
      step(1'b1, K_DATA, d, 1'b1, pc, 1'b0, fa, 1'b1, 1'b0, 1'b0);
   endtask
   task automatic algn(input logic fa, input logic ca);
      step(1'b1, K_PRIM, PRIM_ALIGN, 1'b0, P_NONE, 1'b0, fa, ca, 1'b0, 1'b1);
   endtask
   task automatic err(input logic [3:0] k, input logic [31:0] d, input logic fa, input logic ca);
      step(1'b1, k, d, 1'b0, P_NONE, 1'b0, fa, ca, 1'b1, 1'b0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge sys_clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("prim_valid",   32'(dec.prim_valid),   32'(e.pv));
            chk("prim_code",    32'(dec.prim_code),    32'(e.pc));
            chk("data_valid",   32'(dec.data_valid),   32'(e.dv));
            chk("data_o",       dec.data_o,            e.dout);
            chk("frame_active", 32'(dec.frame_active), 32'(e.fa));
            chk("cont_active",  32'(dec.cont_active),  32'(e.ca));
            chk("err_pulse",    32'(dec.err_pulse),    32'(e.ep));
            chk("err_cnt",      32'(err_cnt),          32'(e.ec));
            chk("align_cnt",    32'(align_cnt),        32'(e.ac));
            chk("err_cnt_sat",  32'(err_cnt2),         32'(sat7(e.ec)));
            chk("align_cnt_sat",32'(align_cnt2),       32'(sat7(e.ac)));
            chk("trig_off",     32'(trig),             32'h0);
            chk("trig_on",      32'(trig2),            32'(e.ep));
         end
      end
   end

   initial begin : driver
      // Reset held: outputs must read all zero.
      rst_mode = 1'b1;
      repeat (2) pr(PRIM_SYNC, P_SYNC, 1'b0, 1'b0);
      rst_mode = 1'b0;

      repeat (3) pr(PRIM_SYNC, P_SYNC, 1'b0, 1'b0);

      algn(1'b0, 1'b0);
      algn(1'b0, 1'b0);
      pr(PRIM_R_RDY, P_R_RDY, 1'b0, 1'b0);

      // X_RDY held via CONT; filler and ALIGN do not end it, SYNC does.
      pr(PRIM_X_RDY, P_X_RDY, 1'b0, 1'b0);
      pr(PRIM_X_RDY, P_X_RDY, 1'b0, 1'b0);
      pr(PRIM_CONT,  P_X_RDY, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) junk(32'h0BAD_0000 | 32'(i * 32'h1111), P_X_RDY, 1'b0);
      algn(1'b0, 1'b1);
      pr(PRIM_SYNC, P_SYNC, 1'b0, 1'b0);

      // Frame with HOLD/CONT: only the two leading payload dwords are delivered.
      pr(PRIM_SOF, P_SOF, 1'b1, 1'b0);
      dat(32'h11223344);
      dat(32'hAABBCCDD);
      pr(PRIM_HOLD, P_HOLD, 1'b1, 1'b0);
      pr(PRIM_CONT, P_HOLD, 1'b1, 1'b1);
      junk(32'hF00DF00D, P_HOLD, 1'b1);
      junk(32'h0F0F0F0F, P_HOLD, 1'b1);
      junk(32'h55667788, P_HOLD, 1'b1);
      pr(PRIM_EOF, P_EOF, 1'b0, 1'b0);

      pr(PRIM_SOF,  P_SOF,  1'b1, 1'b0);
      pr(PRIM_HOLD, P_HOLD, 1'b1, 1'b0);
      pr(PRIM_CONT, P_HOLD, 1'b1, 1'b1);
      junk(32'h55667788, P_HOLD, 1'b1);
      pr(PRIM_WTRM, P_WTRM, 1'b0, 1'b0);

      // SOF inside a frame: primitive reported and error raised together.
      pr(PRIM_SOF, P_SOF, 1'b1, 1'b0);
      step(1'b1, K_PRIM, PRIM_SOF, 1'b1, P_SOF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      pr(PRIM_SYNC, P_SYNC, 1'b0, 1'b0);

      rst_mode = 1'b1;
      pr(PRIM_SYNC, P_SYNC, 1'b0, 1'b0);
      rst_mode = 1'b0;

      err(K_PRIM, PRIM_CONT, 1'b0, 1'b0);
      err(K_DATA, 32'h12345678, 1'b0, 1'b0);
      err(4'b0010, 32'h0000BC00, 1'b0, 1'b0);
      err(K_PRIM, 32'h0000007C, 1'b0, 1'b0);

      // Link drop mid-frame, inside CONT: silent clear, then data is out of frame.
      pr(PRIM_SOF, P_SOF, 1'b1, 1'b0);
      dat(32'hCAFEF00D);
      pr(PRIM_HOLD, P_HOLD, 1'b1, 1'b0);
      pr(PRIM_CONT, P_HOLD, 1'b1, 1'b1);
      step(1'b0, K_DATA, 32'h0, 1'b0, P_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      err(K_DATA, 32'h0BADDA7A, 1'b0, 1'b0);

      pr(PRIM_SOF, P_SOF, 1'b1, 1'b0);
      bia_mode = 1'b0;
      step(1'b1, K_DATA, 32'h00000005, 1'b0, P_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      bia_mode = 1'b1;
      err(K_DATA, 32'h00000006, 1'b0, 1'b0);

      repeat (10) algn(1'b0, 1'b0);
      repeat (10) err(4'b1111, 32'h0, 1'b0, 1'b0);

      @(posedge sys_clk);
      #2;
      chk("scoreboard_drain", 32'(q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
